// File: rtl/modacc_stream_pkg.sv
// modacc_stream_pkg: shared widths, state encoding and reduced-modulus helper for the modular accumulator
package modacc_stream_pkg;
    localparam int MODACC_LOGQ  = 64;
    localparam int MODACC_LOGQH = 47;
    localparam int MODACC_CNTW  = 16;
    localparam int MODACC_W     = MODACC_LOGQ - MODACC_LOGQH;

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2} modacc_state_t;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // One bit of the subtrahend {q[LOGQ-1:W], 0..0, q[0]}: the middle bits of q are zero by construction
    function automatic logic modq_sub_const(input logic q_bit, input int i, input int w);
        return q_bit & ((i == 0) || (i >= w));
    endfunction
endpackage

// File: rtl/modacc_stream_if.sv
// modacc_stream_if: input-beat and result handshake bundle for modacc_stream
interface modacc_stream_if
    import modacc_stream_pkg::*;
#(
    parameter int LOGQ = MODACC_LOGQ,
    parameter int CNTW = MODACC_CNTW
);
    logic [LOGQ-1:0] q;
    logic            in_valid;
    logic            in_ready;
    logic [LOGQ-1:0] in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [LOGQ-1:0] out_data;
    logic [CNTW-1:0] out_count;
    logic            out_err;

    modport slave (
        input  q, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_err
    );

    modport master (
        output q, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_err
    );
endinterface

// File: rtl/modacc_stream_modadd.sv
// modacc_stream_modadd: (a + b) mod q for q of the form {hi, 0..0, 1}, with optional input/add/output register stages
module modacc_stream_modadd
    import modacc_stream_pkg::*;
#(
    parameter int LOGQ   = MODACC_LOGQ,
    parameter int LOGQH  = MODACC_LOGQH,
    parameter int FF_IN  = 0,
    parameter int FF_ADD = 0,
    parameter int FF_OUT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [LOGQ-1:0] a_i,
    input  logic [LOGQ-1:0] b_i,
    input  logic [LOGQ-1:0] q_i,
    output logic [LOGQ-1:0] res_o
);
    localparam int W = LOGQ - LOGQH;

    logic [LOGQ-1:0] a_q, b_q, qr_q, a_s, b_s, q_s;
    logic [LOGQ:0]   sub, sum_d, dif_d, dif_q, dif_s;
    logic [LOGQ-1:0] sum_q, sum_s, res_d, res_q;

    // Add, subtract the reduced modulus once, keep the difference unless it went negative
    always_comb begin
        a_s = (FF_IN != 0) ? a_q : a_i;
        b_s = (FF_IN != 0) ? b_q : b_i;
        q_s = (FF_IN != 0) ? qr_q : q_i;
        sub = '0;
        for (int i = 0; i < LOGQ; i++) sub[i] = modq_sub_const(q_s[i], i, W);
        sum_d = {1'b0, a_s} + {1'b0, b_s};
        dif_d = sum_d - sub;
        sum_s = (FF_ADD != 0) ? sum_q : sum_d[LOGQ-1:0];
        dif_s = (FF_ADD != 0) ? dif_q : dif_d;
        res_d = dif_s[LOGQ] ? sum_s : dif_s[LOGQ-1:0];
        res_o = (FF_OUT != 0) ? res_q : res_d;
    end

    // Pipeline registers; bypassed (and trimmed by synthesis) when the matching FF_* is 0
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            qr_q  <= '0;
            sum_q <= '0;
            dif_q <= '0;
            res_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            qr_q  <= q_i;
            sum_q <= sum_d[LOGQ-1:0];
            dif_q <= dif_d;
            res_q <= res_d;
        end
    end
endmodule

// File: rtl/modacc_stream.sv
// modacc_stream: sums a frame of residues mod q and emits one result per frame; MODACC_RANGE_CHECK_EN adds the in_data >= q error flag
module modacc_stream
    import modacc_stream_pkg::*;
#(
    parameter int LOGQ  = MODACC_LOGQ,
    parameter int LOGQH = MODACC_LOGQH,
    parameter int CNTW  = MODACC_CNTW
) (
    input logic            clk,
    input logic            rst,
    modacc_stream_if.slave bus
);
    logic [1:0]      state_q, state_d;
    logic [LOGQ-1:0] acc_q, acc_d, q_q, q_d, sum;
    logic [CNTW-1:0] cnt_q, cnt_d;

    modacc_stream_modadd #(
        .LOGQ(LOGQ), .LOGQH(LOGQH), .FF_IN(0), .FF_ADD(0), .FF_OUT(0)
    ) u_modadd (
        .clk(clk), .rst(rst), .a_i(acc_q), .b_i(bus.in_data), .q_i(q_q), .res_o(sum)
    );

    assign bus.in_ready  = state_q != S_HOLD;
    assign bus.out_valid = state_q == S_HOLD;
    assign bus.out_data  = acc_q;
    assign bus.out_count = cnt_q;

`ifdef MODACC_RANGE_CHECK_EN
    logic err_q, err_d, beat_err;
    assign beat_err    = bus.in_data >= ((state_q == S_IDLE) ? bus.q : q_q);
    assign bus.out_err = err_q;
`else
    assign bus.out_err = 1'b0;
`endif

    // Frame FSM: first beat loads, later beats accumulate, HOLD presents the result until taken
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
`ifdef MODACC_RANGE_CHECK_EN
        err_d   = err_q;
`endif
        if (state_q == S_IDLE && bus.in_valid) begin
            acc_d   = bus.in_data;
            q_d     = bus.q;
            cnt_d   = CNTW'(1);
            state_d = bus.in_last ? S_HOLD : S_ACC;
`ifdef MODACC_RANGE_CHECK_EN
            err_d   = beat_err;
`endif
        end else if (state_q == S_ACC && bus.in_valid) begin
            acc_d   = sum;
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNTW'(1);
            state_d = bus.in_last ? S_HOLD : S_ACC;
`ifdef MODACC_RANGE_CHECK_EN
            err_d   = err_q | beat_err;
`endif
        end else if (state_q == S_HOLD && bus.out_ready) begin
            state_d = S_IDLE;
        end
    end

    // State and frame registers; reset drops any partial frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
`ifdef MODACC_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
`ifdef MODACC_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end
endmodule
